demux1to5_stream: RTL and testbench
===================================

// Module: demux1to5_stream
// PURPOSE
//  Registered 1-to-5 stream demultiplexer: the inverse path of the team's 5:1 byte mux.
//  Steers one W-bit input stream to one of five output channels under a 3-bit select.
//  Each channel has a one-entry output slot with valid/ready handshake.
//  Out-of-range selects (5..7) are dropped and counted.
// PARAMETERS
//  W      8  data width per beat
//  CNT_W  8  width of saturating drop counter
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        reset, synchronous, active-high
//  in_data    in   W        input beat
//  in_sel     in   3        destination channel, valid 0..4; sampled with in_data
//  in_valid   in   1        input beat present
//  in_ready   out  1        block accepts beat this cycle
//  out_data   out  5*W      channel k data at [k*W +: W]
//  out_valid  out  5        bit k: channel k slot holds a beat
//  out_ready  in   5        bit k: channel k sink takes beat this cycle
//  drop_pulse out  1        one-cycle pulse, one cycle after an out-of-range beat is accepted
//  drop_cnt   out  CNT_W    number of dropped beats, saturating
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0.
//    Reset mid-transfer discards every held beat; in_ready is 0 while rst=1.
//  - Accept = in_valid & in_ready. Transfer on channel k = out_valid[k] & out_ready[k].
//  - in_ready (combinational, rst=0):
//      in_sel<=4: ~out_valid[in_sel] | out_ready[in_sel]  (slot empty or draining this cycle)
//      in_sel>=5: 1 (beat always accepted, then dropped)
//    in_ready depends only on in_sel and the state/ready of the selected channel.
//    It does not depend on in_valid.
//  - Latency: a beat accepted on edge N for channel k appears on out_data[k] with out_valid[k]=1
//    after edge N. Latency is one cycle. Throughput is one beat/cycle per channel.
//  - Slot k update per edge:
//      accept for k          -> data<=in_data, valid<=1 (covers simultaneous drain+load)
//      else transfer on k    -> valid<=0, data held
//      else                  -> hold
//  - Hold rule: while out_valid[k]=1 & out_ready[k]=0, out_data[k] is stable.
//  - out_ready[k] asserted with out_valid[k]=0 has no effect.
//  - Channels are independent. A stalled channel blocks only beats selecting it.
//    There is no head-of-line buffering beyond the input handshake.
//  - Drop path: accept with in_sel in 5..7 -> no slot changes.
//    drop_pulse=1 for exactly the next cycle, and drop_cnt increments.
//  - drop_cnt saturates at 2^CNT_W-1 and never wraps. drop_pulse still fires when saturated.
//  - Back-to-back drops give drop_pulse high on consecutive cycles.
//  - No state machine beyond per-slot valid bits. The drop path is a registered pulse plus counter.
// STRUCTURE
//  - Shared header demux_defs.vh: NCH=5, SEL_W=3, SEL_MAX=3'd4.
//  - Sub-module demux_slot (W param; clk, rst, load, ld_data, ready, valid, data) is instantiated 5x.
//    It holds the load-over-drain priority rule above.
//  - Top level holds in_ready decode, select decode, drop register and saturating counter.
// TESTING
//  1. rst=1 for 2 cycles, then release.
//     -> out_valid=5'b0, out_data=0, drop_cnt=0, in_ready=1 for every in_sel with out_ready=0.
//  2. in_sel=2, in_data=8'hA5, in_valid=1 for 1 cycle, out_ready=0.
//     -> next cycle out_valid=5'b00100, out_data[23:16]=A5.
//     Then send in_sel=2 with 8'h3C: in_ready=0, data holds A5.
//  3. Channel 2 full with A5. Set out_ready[2]=1 and present 8'h3C, sel 2 in the same cycle.
//     -> accept, out_valid[2] stays 1, data becomes 3C next cycle.
//  4. Stream sel=0,1,2,3,4 with data 11..55 on consecutive cycles, all out_ready=1.
//     -> each channel shows its byte exactly 1 cycle after acceptance, in_ready stays 1.
//  5. in_sel=6, in_data=8'hFF, valid 1 cycle.
//     -> in_ready=1, no out_valid change, drop_pulse=1 next cycle, drop_cnt=1.
//     With CNT_W=2, 5 drops -> drop_cnt=3, 5 pulses.
//  6. Load channel 4, then assert rst for 1 cycle while out_valid[4]=1.
//     -> out_valid=0 and drop_cnt=0 after the edge. The beat is not delivered.

Source files
------------

// File: rtl/demux1to5_stream_pkg.sv
// Shared constants and helpers for the 1-to-5 stream demultiplexer.
package demux1to5_stream_pkg;

  localparam int unsigned NCH   = 5;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

  // Selects above SEL_MAX address no channel and cause the beat to be dropped
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    return (sel <= SEL_MAX);
  endfunction

endpackage

// File: rtl/demux1to5_stream_slot.sv
// One-entry output slot with valid/ready handshake; a load wins over a drain.
module demux1to5_stream_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load covers simultaneous drain+load; data is held after a plain drain
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux1to5_stream.sv
// Registered 1-to-5 stream demultiplexer with per-channel output slots and drop counting.
module demux1to5_stream
  import demux1to5_stream_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NCH*W-1:0]   out_data,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic               drop_pulse,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic             sel_ok;
  logic [NCH-1:0]   sel_oh;
  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   load;
  logic             accept;
  logic             drop_d, drop_q;
  logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

  assign sel_ok = sel_in_range(in_sel);

  always_comb begin
    sel_oh = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sel_oh[k] = (in_sel == SEL_W'(k));
    end
  end

  // A slot can take a beat when empty or when it drains on this same edge
  assign slot_free = ~out_valid | out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = sel_ok ? |(sel_oh & slot_free) : 1'b1;
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = {NCH{accept}} & sel_oh;
  assign drop_d = accept & ~sel_ok;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_q;
  assign drop_cnt   = drop_cnt_q;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux1to5_stream_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .ld_data (in_data),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*W +: W])
    );
  end

endmodule

// File: tb/tb_demux1to5_stream.sv
// Directed self-checking bench for demux1to5_stream (CNT_W=8 and CNT_W=2 instances).
module tb_demux1to5_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic [4:0]  out_ready;

  logic        d8_in_ready, d2_in_ready;
  logic [39:0] d8_out_data, d2_out_data;
  logic [4:0]  d8_out_valid, d2_out_valid;
  logic        d8_drop_pulse, d2_drop_pulse;
  logic [7:0]  d8_drop_cnt;
  logic [1:0]  d2_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux1to5_stream #(.W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(d8_in_ready), .out_data(d8_out_data), .out_valid(d8_out_valid),
    .out_ready(out_ready), .drop_pulse(d8_drop_pulse), .drop_cnt(d8_drop_cnt)
  );

  demux1to5_stream #(.W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(d2_in_ready), .out_data(d2_out_data), .out_valid(d2_out_valid),
    .out_ready(out_ready), .drop_pulse(d2_drop_pulse), .drop_cnt(d2_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 5'b0;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %b exp 0", d8_in_ready);
    end
    tick(); tick();
    n_checks++;
    if (d8_out_valid !== 5'b0 || d2_out_valid !== 5'b0) begin
      n_fail++; $display("FAIL reset_valid got %b/%b exp 00000", d8_out_valid, d2_out_valid);
    end
    n_checks++;
    if (d8_out_data !== 40'h0 || d2_out_data !== 40'h0) begin
      n_fail++; $display("FAIL reset_data got %h/%h exp 0", d8_out_data, d2_out_data);
    end
    n_checks++;
    if (d8_drop_cnt !== 8'd0 || d2_drop_cnt !== 2'd0 || d8_drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop got cnt %0d/%0d pulse %b exp 0", d8_drop_cnt, d2_drop_cnt, d8_drop_pulse);
    end
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      n_checks++;
      if (d8_in_ready !== 1'b1 || d2_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL idle_in_ready sel %0d got %b/%b exp 1", s, d8_in_ready, d2_in_ready);
      end
    end
  endtask

  task automatic test_load_and_stall();
    in_sel = 3'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 5'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (d8_out_valid !== 5'b00100) begin
      n_fail++; $display("FAIL load_valid got %b exp 00100", d8_out_valid);
    end
    n_checks++;
    if (d8_out_data[23:16] !== 8'hA5) begin
      n_fail++; $display("FAIL load_data got %h exp a5", d8_out_data[23:16]);
    end
    in_data = 8'h3C; in_valid = 1'b1;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready got %b exp 0", d8_in_ready);
    end
    in_sel = 3'd1;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL other_chan_in_ready got %b exp 1", d8_in_ready);
    end
    in_sel = 3'd2;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (d8_out_data[23:16] !== 8'hA5 || d8_out_valid !== 5'b00100) begin
      n_fail++; $display("FAIL stall_hold got %h/%b exp a5/00100", d8_out_data[23:16], d8_out_valid);
    end
  endtask

  task automatic test_drain_and_load();
    in_sel = 3'd2; in_data = 8'h3C; in_valid = 1'b1; out_ready = 5'b00100;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drainload_in_ready got %b exp 1", d8_in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 5'b0;
    n_checks++;
    if (d8_out_valid !== 5'b00100 || d8_out_data[23:16] !== 8'h3C) begin
      n_fail++; $display("FAIL drainload_slot got %b/%h exp 00100/3c", d8_out_valid, d8_out_data[23:16]);
    end
    out_ready = 5'b00100;
    tick();
    out_ready = 5'b0;
    n_checks++;
    if (d8_out_valid !== 5'b0 || d8_out_data[23:16] !== 8'h3C) begin
      n_fail++; $display("FAIL drain_only got %b/%h exp 00000/3c", d8_out_valid, d8_out_data[23:16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_byte;
    out_ready = 5'b11111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel = 3'(i);
      exp_byte = 8'(8'h11 * (i + 1));
      in_data = exp_byte;
      #1;
      n_checks++;
      if (d8_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_in_ready ch %0d got %b exp 1", i, d8_in_ready);
      end
      tick();
      n_checks++;
      if (d8_out_valid !== 5'(1 << i) || d2_out_valid !== 5'(1 << i)) begin
        n_fail++; $display("FAIL stream_valid ch %0d got %b exp %b", i, d8_out_valid, 5'(1 << i));
      end
      n_checks++;
      if (d8_out_data[i*8 +: 8] !== exp_byte) begin
        n_fail++; $display("FAIL stream_data ch %0d got %h exp %h", i, d8_out_data[i*8 +: 8], exp_byte);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 5'b0;
    n_checks++;
    if (d8_out_valid !== 5'b0) begin
      n_fail++; $display("FAIL stream_drained got %b exp 00000", d8_out_valid);
    end
  endtask

  task automatic test_drop();
    logic [2:0] sels [4];
    sels[0] = 3'd5; sels[1] = 3'd7; sels[2] = 3'd5; sels[3] = 3'd6;
    in_sel = 3'd6; in_data = 8'hFF; in_valid = 1'b1; out_ready = 5'b0;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drop_in_ready got %b exp 1", d8_in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (d8_drop_pulse !== 1'b1 || d8_drop_cnt !== 8'd1 || d2_drop_cnt !== 2'd1) begin
      n_fail++; $display("FAIL drop_first got pulse %b cnt %0d/%0d exp 1 1/1", d8_drop_pulse, d8_drop_cnt, d2_drop_cnt);
    end
    n_checks++;
    if (d8_out_valid !== 5'b0) begin
      n_fail++; $display("FAIL drop_no_slot got %b exp 00000", d8_out_valid);
    end
    tick();
    n_checks++;
    if (d8_drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL drop_pulse_width got %b exp 0", d8_drop_pulse);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = sels[i];
      tick();
      n_checks++;
      if (d8_drop_pulse !== 1'b1 || d2_drop_pulse !== 1'b1) begin
        n_fail++; $display("FAIL drop_b2b %0d got %b/%b exp 1", i, d8_drop_pulse, d2_drop_pulse);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (d8_drop_cnt !== 8'd5) begin
      n_fail++; $display("FAIL drop_cnt8 got %0d exp 5", d8_drop_cnt);
    end
    n_checks++;
    if (d2_drop_cnt !== 2'd3) begin
      n_fail++; $display("FAIL drop_cnt2_sat got %0d exp 3", d2_drop_cnt);
    end
    n_checks++;
    if (d8_out_data !== 40'h5544332211 || d8_out_valid !== 5'b0) begin
      n_fail++; $display("FAIL drop_slots_untouched got %h/%b exp 5544332211/00000", d8_out_data, d8_out_valid);
    end
    tick();
    n_checks++;
    if (d2_drop_pulse !== 1'b0 || d2_drop_cnt !== 2'd3) begin
      n_fail++; $display("FAIL drop_idle got %b/%0d exp 0/3", d2_drop_pulse, d2_drop_cnt);
    end
  endtask

  task automatic test_reset_mid_transfer();
    in_sel = 3'd4; in_data = 8'h9E; in_valid = 1'b1; out_ready = 5'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (d8_out_valid !== 5'b10000 || d8_out_data[39:32] !== 8'h9E) begin
      n_fail++; $display("FAIL mid_load got %b/%h exp 10000/9e", d8_out_valid, d8_out_data[39:32]);
    end
    rst = 1'b1; out_ready = 5'b10000;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b0 || d2_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_in_ready got %b/%b exp 0", d8_in_ready, d2_in_ready);
    end
    tick();
    rst = 1'b0; out_ready = 5'b0;
    n_checks++;
    if (d8_out_valid !== 5'b0 || d2_out_valid !== 5'b0) begin
      n_fail++; $display("FAIL mid_rst_valid got %b/%b exp 00000", d8_out_valid, d2_out_valid);
    end
    n_checks++;
    if (d8_drop_cnt !== 8'd0 || d2_drop_cnt !== 2'd0 || d8_out_data !== 40'h0) begin
      n_fail++; $display("FAIL mid_rst_state got cnt %0d/%0d data %h exp 0", d8_drop_cnt, d2_drop_cnt, d8_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_stall();
    test_drain_and_load();
    test_back_to_back();
    test_drop();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
